vga_layer_mixer: RTL
====================

// Module: vga_layer_mixer
// PURPOSE
//  Display-side counterpart to the sprite layers (me, enemy, bullet, background).
//  Generates 640x480@60 VGA timing and drives req_x/req_y pixel requests plus v_sync to every layer.
//  Collects each layer's alpha/rgb, priority-composites them to the VGA pins, and raises the crash
//  strobes the enemy layer consumes when opaque pixels of two layers coincide.
// PARAMETERS
//  H_DISP 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, in pixel clocks
//  V_DISP 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing, in lines
//  ADDR_W 10        : req_x/req_y width (equal to H_DISP_LEN)
//  RGB_W 12         : pixel width (equal to COLOR_RGB_DEPTH)
//  NUM_LAYERS 4     : layer inputs; index 0 has the highest priority
//  ME_IDX 0, BULLET_IDX 1, ENEMY_IDX 2 : layer roles used for crash detection
//  LAYER_LAT 1      : clk_vga cycles from a request to valid layer alpha/rgb
//  BG_RGB 12'h000   : colour shown where no layer is opaque
// PORTS
//  clk_vga               in  1                 pixel clock
//  rst_n                 in  1                 asynchronous reset, active low
//  en_i                  in  1                 1 = composite layers; 0 = force black, timing keeps running
//  layer_alpha_i         in  NUM_LAYERS        per-layer opaque flag for the requested pixel
//  layer_rgb_i           in  NUM_LAYERS*RGB_W  per-layer colour; layer k occupies [k*RGB_W +: RGB_W]
//  req_x_addr_o          out ADDR_W            requested column; all-ones outside active video
//  req_y_addr_o          out ADDR_W            requested row; all-ones outside active video
//  v_sync_o              out 1                 undelayed vertical sync to the layers (low during pulse)
//  frame_start_o         out 1                 1-cycle pulse at h=0, v=0
//  crash_enemy_bullet_o  out 1                 enemy alpha AND bullet alpha
//  crash_me_enemy_o      out 1                 me alpha AND enemy alpha
//  vga_hs_o, vga_vs_o    out 1                 pin syncs, active low, aligned with vga_rgb_o
//  vga_rgb_o             out RGB_W             registered composite pixel
// BEHAVIOUR
//  - h_cnt: 0..H_TOTAL-1 (800). v_cnt: 0..V_TOTAL-1 (525), advances when h_cnt wraps; both wrap to 0.
//  - Active video: h_cnt<H_DISP && v_cnt<V_DISP. In active video req = counters; otherwise all-ones.
//  - hs is low for H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC. vs follows the same rule on v_cnt.
//  - Request at cycle t, layer data at t+LAYER_LAT, vga_rgb_o registered at t+LAYER_LAT+1.
//  - vga_hs_o, vga_vs_o and the active flag go through a (LAYER_LAT+1)-deep shift register so they
//    stay aligned with vga_rgb_o. v_sync_o is not delayed.
//  - Mix: the lowest index k with alpha[k]=1 wins; no opaque layer -> BG_RGB.
//    The delayed active flag is 0 or en_i=0 -> 12'h000.
//  - Crash strobes are combinational from layer_alpha_i, gated by the active flag delayed LAYER_LAT.
//    They are high for every overlapping pixel, so a layer sees them in the same cycle as its alpha.
//    Both strobes may be high together.
//  - Reset values: counters 0, all shift stages inactive with syncs high, vga_rgb_o=0, crash outputs 0,
//    frame_start_o=0. req outputs decode (0,0). Reset mid-frame restarts at h=0, v=0 on release.
//  - frame_start_o is registered and asserts in the cycle after the counters reach (0,0).
//    The first frame after reset is also signalled.
// CONFIGURATION
//  VGA_MIXER_CRASH_LATCH_EN defined: adds output crash_flags_o [1:0] = {me_enemy, enemy_bullet}.
//    Each bit is sticky: set by its strobe, cleared only in the cycle frame_start_o pulses.
//    A strobe in that same cycle wins, so the bit is set.
//  VGA_MIXER_CRASH_LATCH_EN undefined: the port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared header (define.v): H_/V_ timing constants, H_TOTAL and V_TOTAL, layer index constants,
//    RGB and address widths.
//  - One sub-module, vga_timing_gen: counters, active flag, undelayed syncs, req decode.
//  - The top level holds the alignment shift register, priority mux, crash logic and the optional latch.
// TESTING
//  - Reset held then released: rgb=0, hs=vs=1. The first frame_start_o comes 1 cycle after release.
//    Line period is 800 clocks, frame period 420000 clocks.
//  - hs low for exactly 96 clocks starting at h=656; vs low for exactly 2 lines starting at v=490.
//    req=all-ones at h=640.
//  - alpha=4'b0110, rgb1=12'hF00, rgb2=12'h0F0 at req (10,10) -> vga_rgb_o=12'hF00 at LAYER_LAT+1.
//    alpha=0 -> 12'h000 (BG_RGB).
//  - alpha[ENEMY]=alpha[BULLET]=1 inside active video -> crash_enemy_bullet_o=1 in the same cycle.
//    The same alphas during blanking -> 0.
//  - en_i=0 with opaque layers -> vga_rgb_o=0 while hs/vs timing is unchanged.
//    Assert rst_n low mid-line -> counters return to 0.
//  - With VGA_MIXER_CRASH_LATCH_EN: one crash pixel sets crash_flags_o=2'b01.
//    The flag holds until the next frame_start_o, then reads 0.

Source files
------------

// File: rtl/vga_layer_mixer_pkg.sv
// Shared constants, types and helpers for the VGA layer mixer: 640x480@60 timing,
// layer roles, and the control word that is carried alongside the pixel pipeline.
package vga_layer_mixer_pkg;

   localparam int unsigned H_DISP  = 640;
   localparam int unsigned H_FP    = 16;
   localparam int unsigned H_SYNC  = 96;
   localparam int unsigned H_BP    = 48;
   localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_DISP  = 480;
   localparam int unsigned V_FP    = 10;
   localparam int unsigned V_SYNC  = 2;
   localparam int unsigned V_BP    = 33;
   localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned RGB_W      = 12;
   localparam int unsigned NUM_LAYERS = 4;
   localparam int unsigned ME_IDX     = 0;
   localparam int unsigned BULLET_IDX = 1;
   localparam int unsigned ENEMY_IDX  = 2;
   localparam int unsigned LAYER_LAT  = 1;

   localparam logic [RGB_W-1:0] BG_RGB = 12'h000;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } vid_ctrl_t;

   localparam vid_ctrl_t CTRL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

   // Lowest-index opaque layer wins; background when none is opaque.
   function automatic logic [RGB_W-1:0] pick_layer(
      input logic [NUM_LAYERS-1:0]       alpha,
      input logic [NUM_LAYERS*RGB_W-1:0] rgb
   );
      logic [RGB_W-1:0] pix;
      pix = BG_RGB;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (alpha[k]) pix = rgb[k*RGB_W +: RGB_W];
      end
      return pix;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster counters: active flag, undelayed syncs, pixel request decode and a
// registered frame-start pulse one cycle after the counters sit at (0,0).
module vga_timing_gen #(
   parameter int unsigned H_DISP = vga_layer_mixer_pkg::H_DISP,
   parameter int unsigned H_FP   = vga_layer_mixer_pkg::H_FP,
   parameter int unsigned H_SYNC = vga_layer_mixer_pkg::H_SYNC,
   parameter int unsigned H_BP   = vga_layer_mixer_pkg::H_BP,
   parameter int unsigned V_DISP = vga_layer_mixer_pkg::V_DISP,
   parameter int unsigned V_FP   = vga_layer_mixer_pkg::V_FP,
   parameter int unsigned V_SYNC = vga_layer_mixer_pkg::V_SYNC,
   parameter int unsigned V_BP   = vga_layer_mixer_pkg::V_BP
) (
   input  logic                                   clk_vga,
   input  logic                                   rst_n,
   output logic                                   active_c,
   output logic                                   hs_c,
   output logic                                   vs_c,
   output logic [vga_layer_mixer_pkg::ADDR_W-1:0] req_x_c,
   output logic [vga_layer_mixer_pkg::ADDR_W-1:0] req_y_c,
   output logic                                   frame_start_o
);
   import vga_layer_mixer_pkg::*;

   localparam int unsigned HT  = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT  = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int unsigned HCW = $clog2(HT);
   localparam int unsigned VCW = $clog2(VT);

   logic [HCW-1:0] h_q, h_d;
   logic [VCW-1:0] v_q, v_d;
   logic           frame_start_q, frame_start_d;

   always_comb begin
      h_d           = h_q + HCW'(1);
      v_d           = v_q;
      frame_start_d = (h_q == '0) && (v_q == '0);
      if (h_q == HCW'(HT - 1)) begin
         h_d = '0;
         v_d = (v_q == VCW'(VT - 1)) ? '0 : v_q + VCW'(1);
      end
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         h_q           <= '0;
         v_q           <= '0;
         frame_start_q <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Raster decode from the current counter values.
   always_comb begin
      active_c = (h_q < HCW'(H_DISP)) && (v_q < VCW'(V_DISP));
      hs_c     = !((h_q >= HCW'(H_DISP + H_FP)) && (h_q < HCW'(H_DISP + H_FP + H_SYNC)));
      vs_c     = !((v_q >= VCW'(V_DISP + V_FP)) && (v_q < VCW'(V_DISP + V_FP + V_SYNC)));
      req_x_c  = active_c ? ADDR_W'(h_q) : '1;
      req_y_c  = active_c ? ADDR_W'(v_q) : '1;
   end

   assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_layer_mixer.sv
// VGA layer compositor: timing, sync/active alignment with the layer latency, priority mux
// and crash strobes. Optional sticky crash flags under VGA_MIXER_CRASH_LATCH_EN.
module vga_layer_mixer #(
   parameter int unsigned H_DISP = vga_layer_mixer_pkg::H_DISP,
   parameter int unsigned H_FP   = vga_layer_mixer_pkg::H_FP,
   parameter int unsigned H_SYNC = vga_layer_mixer_pkg::H_SYNC,
   parameter int unsigned H_BP   = vga_layer_mixer_pkg::H_BP,
   parameter int unsigned V_DISP = vga_layer_mixer_pkg::V_DISP,
   parameter int unsigned V_FP   = vga_layer_mixer_pkg::V_FP,
   parameter int unsigned V_SYNC = vga_layer_mixer_pkg::V_SYNC,
   parameter int unsigned V_BP   = vga_layer_mixer_pkg::V_BP
) (
   input  logic                                                             clk_vga,
   input  logic                                                             rst_n,
   input  logic                                                             en_i,
   input  logic [vga_layer_mixer_pkg::NUM_LAYERS-1:0]                       layer_alpha_i,
   input  logic [vga_layer_mixer_pkg::NUM_LAYERS*vga_layer_mixer_pkg::RGB_W-1:0] layer_rgb_i,
   output logic [vga_layer_mixer_pkg::ADDR_W-1:0]                           req_x_addr_o,
   output logic [vga_layer_mixer_pkg::ADDR_W-1:0]                           req_y_addr_o,
   output logic                                                             v_sync_o,
   output logic                                                             frame_start_o,
   output logic                                                             crash_enemy_bullet_o,
   output logic                                                             crash_me_enemy_o,
   output logic                                                             vga_hs_o,
   output logic                                                             vga_vs_o,
   output logic [vga_layer_mixer_pkg::RGB_W-1:0]                            vga_rgb_o
`ifdef VGA_MIXER_CRASH_LATCH_EN
   ,output logic [1:0]                                                      crash_flags_o
`endif
);
   import vga_layer_mixer_pkg::*;

   localparam int unsigned DEPTH = LAYER_LAT + 1;

   logic      active_c, hs_c, vs_c;
   vid_ctrl_t ctrl_q [DEPTH];
   vid_ctrl_t ctrl_d [DEPTH];
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic      data_active;

   vga_timing_gen #(
      .H_DISP (H_DISP), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_DISP (V_DISP), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk_vga       (clk_vga),
      .rst_n         (rst_n),
      .active_c      (active_c),
      .hs_c          (hs_c),
      .vs_c          (vs_c),
      .req_x_c       (req_x_addr_o),
      .req_y_c       (req_y_addr_o),
      .frame_start_o (frame_start_o)
   );

   // Stage k holds the control word of the request issued k+1 cycles ago.
   always_comb begin
      ctrl_d[0] = '{active: active_c, hs: hs_c, vs: vs_c};
      for (int i = 1; i < DEPTH; i++) ctrl_d[i] = ctrl_q[i-1];
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ctrl_q[i] <= CTRL_IDLE;
         rgb_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ctrl_q[i] <= ctrl_d[i];
         rgb_q <= rgb_d;
      end
   end

   // Layer data arriving now belongs to the request LAYER_LAT cycles back.
   assign data_active = ctrl_q[LAYER_LAT-1].active;

   always_comb begin
      rgb_d = '0;
      if (en_i && data_active) rgb_d = pick_layer(layer_alpha_i, layer_rgb_i);
   end

   assign crash_enemy_bullet_o = data_active & layer_alpha_i[ENEMY_IDX] & layer_alpha_i[BULLET_IDX];
   assign crash_me_enemy_o     = data_active & layer_alpha_i[ME_IDX]    & layer_alpha_i[ENEMY_IDX];

   assign v_sync_o  = vs_c;
   assign vga_hs_o  = ctrl_q[DEPTH-1].hs;
   assign vga_vs_o  = ctrl_q[DEPTH-1].vs;
   assign vga_rgb_o = rgb_q;

`ifdef VGA_MIXER_CRASH_LATCH_EN
   logic [1:0] crash_flags_q, crash_flags_d;

   // A strobe in the frame-start cycle overrides the clear.
   always_comb begin
      crash_flags_d = frame_start_o ? 2'b00 : crash_flags_q;
      crash_flags_d = crash_flags_d | {crash_me_enemy_o, crash_enemy_bullet_o};
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) crash_flags_q <= 2'b00;
      else        crash_flags_q <= crash_flags_d;
   end

   assign crash_flags_o = crash_flags_q;
`endif

endmodule
